compute_unit_seq: RTL and testbench

- Parametrised next-generation datapath computation stage.
- Operand select (asel/bsel), barrel-free 1-bit shifter, and an extended ALU: add, sub, and, not, or, xor, and a multi-cycle multiply.
- Adds a valid/ready handshake and registered C/status outputs.
- Sits between the register-file read ports and the write-back mux; the controller FSM issues ops and consumes out_valid.

---
 rtl/compute_unit_seq_pkg.sv | 28 ++
 rtl/compute_unit_seq_mul_seq.sv | 64 ++++++
 rtl/compute_unit_seq.sv | 146 ++++++++++++++
 tb/tb_compute_unit_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/compute_unit_seq_pkg.sv
// Shared encodings for the compute stage and the controller FSM that drives it:
// ALU op codes, shifter codes, status bit positions and unit states.
package compute_unit_seq_pkg;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_NOT = 3'd3;
   localparam logic [2:0] ALU_MUL = 3'd4;
   localparam logic [2:0] ALU_OR  = 3'd5;
   localparam logic [2:0] ALU_XOR = 3'd6;
   localparam logic [2:0] ALU_RSV = 3'd7;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;

   localparam int ST_Z = 0;
   localparam int ST_N = 1;
   localparam int ST_V = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

endpackage

// File: rtl/compute_unit_seq_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles.
// done and product are combinational during the last iteration so the caller
// can register the final result on the same edge.
module mul_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_next;

   always_comb begin
      acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
      done     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
      product  = acc_next;
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      if (start) begin
         busy_d = 1'b1;
         cnt_d  = '0;
      end else if (done) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (busy_q) begin
         cnt_d  = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   // Datapath registers carry no reset; busy_q qualifies them.
   always_ff @(posedge clk) begin
      if (start) begin
         mcand_q  <= {{WIDTH{1'b0}}, a};
         mplier_q <= b;
         acc_q    <= '0;
      end else if (busy_q) begin
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         acc_q    <= acc_next;
      end
   end

endmodule

// File: rtl/compute_unit_seq.sv
// Datapath compute stage: operand select, 1-bit shifter, ALU with sequential
// multiply, valid/ready handshake and registered C/status outputs.
module compute_unit_seq
   import compute_unit_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             asel,
   input  logic             bsel,
   input  logic             loadc,
   input  logic             loads,
   input  logic [1:0]       shift,
   input  logic [2:0]       aluop,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] imm,
   output logic             out_valid,
   output logic [WIDTH-1:0] C,
   output logic [2:0]       status
);

   function automatic logic [2:0] pack_flags(input logic [WIDTH-1:0] r, input logic v);
      logic [2:0] f;
      f       = '0;
      f[ST_Z] = (r == '0);
      f[ST_N] = r[WIDTH-1];
      f[ST_V] = v;
      return f;
   endfunction

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   c_q, c_d;
   logic [2:0]         status_q, status_d;
   logic               out_valid_q, out_valid_d;
   logic               loadc_q, loadc_d, loads_q, loads_d;

   logic [WIDTH-1:0]   ain, bsh, bin, res;
   logic               alu_v, accept, mul_start, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   always_comb begin
      ain = asel ? '0 : A;
      case (shift)
         SH_LSL:  bsh = {B[WIDTH-2:0], 1'b0};
         SH_LSR:  bsh = {1'b0, B[WIDTH-1:1]};
         SH_ASR:  bsh = {B[WIDTH-1], B[WIDTH-1:1]};
         default: bsh = B;
      endcase
      bin = bsel ? imm : bsh;

      res   = '0;
      alu_v = 1'b0;
      case (aluop)
         ALU_ADD: begin
            res   = ain + bin;
            alu_v = (ain[WIDTH-1] == bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
         end
         ALU_SUB: begin
            res   = ain - bin;
            alu_v = (ain[WIDTH-1] != bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
         end
         ALU_AND: res = ain & bin;
         ALU_NOT: res = ~bin;
         ALU_OR:  res = ain | bin;
         ALU_XOR: res = ain ^ bin;
         default: res = '0;
      endcase
   end

   assign in_ready  = (state_q == ST_IDLE) && !reset;
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (aluop == ALU_MUL);

   mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (ain),
      .b       (bin),
      .done    (mul_done),
      .product (mul_prod)
   );

   // loadc/loads are captured at acceptance so a multiply honours the
   // write enables of the op that started it, not whatever is on the bus later.
   always_comb begin
      state_d     = state_q;
      c_d         = c_q;
      status_d    = status_q;
      out_valid_d = 1'b0;
      loadc_d     = loadc_q;
      loads_d     = loads_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               loadc_d = loadc;
               loads_d = loads;
               if (aluop == ALU_MUL) begin
                  state_d = ST_MUL;
               end else begin
                  out_valid_d = 1'b1;
                  if (loadc) c_d = res;
                  if (loads) status_d = pack_flags(res, alu_v);
               end
            end
         end
         ST_MUL: begin
            if (mul_done) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b1;
               if (loadc_q) c_d = mul_prod[WIDTH-1:0];
               if (loads_q) status_d = pack_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH]);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         c_q         <= '0;
         status_q    <= '0;
         out_valid_q <= 1'b0;
         loadc_q     <= 1'b0;
         loads_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         status_q    <= status_d;
         out_valid_q <= out_valid_d;
         loadc_q     <= loadc_d;
         loads_q     <= loads_d;
      end
   end

   assign C         = c_q;
   assign status    = status_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_compute_unit_seq.sv
// Directed bench for compute_unit_seq at WIDTH=16; inputs change and outputs
// are sampled on the falling edge.
module tb_compute_unit_seq;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset, in_valid, in_ready, asel, bsel, loadc, loads, out_valid;
   logic [1:0]   shift;
   logic [2:0]   aluop, status;
   logic [W-1:0] a_in, b_in, imm_in, c_out;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   compute_unit_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .asel      (asel),
      .bsel      (bsel),
      .loadc     (loadc),
      .loads     (loads),
      .shift     (shift),
      .aluop     (aluop),
      .A         (a_in),
      .B         (b_in),
      .imm       (imm_in),
      .out_valid (out_valid),
      .C         (c_out),
      .status    (status)
   );

   task automatic drive_op(input logic as, input logic bs, input logic lc, input logic ls,
                           input logic [1:0] sh, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] im);
      in_valid = 1'b1; asel = as; bsel = bs; loadc = lc; loads = ls;
      shift = sh; aluop = op; a_in = a; b_in = b; imm_in = im;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; asel = 0; bsel = 0; loadc = 0; loads = 0;
      shift = 2'b00; aluop = 3'd0; a_in = '0; b_in = '0; imm_in = '0;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (c_out !== 16'h0000) begin errors++; $display("FAIL reset_C: got %h want 0000", c_out); end
      checks++; if (status !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", status); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_add_overflow();
      drive_op(0, 0, 1, 1, 2'b00, 3'd0, 16'h7FFF, 16'h0001, 16'h0000);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_ovf_valid: got %b want 1", out_valid); end
      checks++; if (c_out !== 16'h8000) begin errors++; $display("FAIL add_ovf_C: got %h want 8000", c_out); end
      checks++; if (status !== 3'b110) begin errors++; $display("FAIL add_ovf_status: got %b want 110", status); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_ovf_pulse_end: got %b want 0", out_valid); end
   endtask

   task automatic test_sub_loads();
      drive_op(0, 0, 1, 1, 2'b00, 3'd1, 16'd5, 16'd5, 16'h0000);
      @(negedge clk);
      checks++; if (c_out !== 16'h0000) begin errors++; $display("FAIL sub_zero_C: got %h want 0000", c_out); end
      checks++; if (status !== 3'b001) begin errors++; $display("FAIL sub_zero_status: got %b want 001", status); end
      drive_op(0, 0, 1, 0, 2'b00, 3'd0, 16'd1, 16'd1, 16'h0000);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (c_out !== 16'h0002) begin errors++; $display("FAIL noloads_C: got %h want 0002", c_out); end
      checks++; if (status !== 3'b001) begin errors++; $display("FAIL noloads_status: got %b want 001", status); end
   endtask

   task automatic test_shift_bsel();
      drive_op(0, 0, 1, 1, 2'b11, 3'd3, 16'h1234, 16'h8002, 16'h0000);
      @(negedge clk);
      checks++; if (c_out !== 16'h3FFE) begin errors++; $display("FAIL asr_not_C: got %h want 3FFE", c_out); end
      checks++; if (status !== 3'b000) begin errors++; $display("FAIL asr_not_status: got %b want 000", status); end
      drive_op(0, 1, 1, 1, 2'b00, 3'd0, 16'h0010, 16'h5555, 16'hFFF0);
      @(negedge clk);
      checks++; if (c_out !== 16'h0000) begin errors++; $display("FAIL imm_add_C: got %h want 0000", c_out); end
      checks++; if (status !== 3'b001) begin errors++; $display("FAIL imm_add_status: got %b want 001", status); end
      drive_op(0, 0, 1, 1, 2'b01, 3'd0, 16'h0000, 16'h4001, 16'h0000);
      @(negedge clk);
      checks++; if (c_out !== 16'h8002) begin errors++; $display("FAIL lsl_C: got %h want 8002", c_out); end
      drive_op(1, 0, 1, 1, 2'b10, 3'd5, 16'hFFFF, 16'h8002, 16'h0000);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (c_out !== 16'h4001) begin errors++; $display("FAIL lsr_asel_C: got %h want 4001", c_out); end
   endtask

   task automatic test_mul();
      drive_op(0, 0, 1, 1, 2'b00, 3'd4, 16'd300, 16'd300, 16'h0000);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy_ready cyc %0d: got %b want 0", i, in_ready); end
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_busy_valid cyc %0d: got %b want 0", i, out_valid); end
         if (i == 1) drive_op(0, 0, 1, 1, 2'b00, 3'd0, 16'h1111, 16'h1111, 16'h0000);
         if (i == 16) in_valid = 1'b0;
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_done_valid: got %b want 1", out_valid); end
      checks++; if (c_out !== 16'h5F90) begin errors++; $display("FAIL mul_300_C: got %h want 5F90", c_out); end
      checks++; if (status !== 3'b100) begin errors++; $display("FAIL mul_300_status: got %b want 100", status); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_done_ready: got %b want 1", in_ready); end
      drive_op(0, 0, 1, 1, 2'b00, 3'd4, 16'd3, 16'd4, 16'h0000);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (16) @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_small_valid: got %b want 1", out_valid); end
      checks++; if (c_out !== 16'h000C) begin errors++; $display("FAIL mul_small_C: got %h want 000C", c_out); end
      checks++; if (status !== 3'b000) begin errors++; $display("FAIL mul_small_status: got %b want 000", status); end
   endtask

   task automatic test_back_to_back();
      drive_op(0, 0, 1, 1, 2'b00, 3'd0, 16'h1234, 16'h0101, 16'h0000);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || c_out !== 16'h1335) begin errors++; $display("FAIL b2b_add: got v=%b C=%h want v=1 C=1335", out_valid, c_out); end
      drive_op(0, 0, 1, 1, 2'b00, 3'd2, 16'hF0F0, 16'h0FF0, 16'h0000);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || c_out !== 16'h00F0) begin errors++; $display("FAIL b2b_and: got v=%b C=%h want v=1 C=00F0", out_valid, c_out); end
      drive_op(0, 0, 1, 1, 2'b00, 3'd7, 16'h1234, 16'h5678, 16'h0000);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || c_out !== 16'h0000 || status !== 3'b001) begin errors++; $display("FAIL b2b_rsv: got v=%b C=%h st=%b want v=1 C=0000 st=001", out_valid, c_out, status); end
      drive_op(0, 0, 1, 1, 2'b00, 3'd6, 16'hFF00, 16'h0FF0, 16'h0000);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || c_out !== 16'hF0F0 || status !== 3'b010) begin errors++; $display("FAIL b2b_xor: got v=%b C=%h st=%b want v=1 C=F0F0 st=010", out_valid, c_out, status); end
      drive_op(0, 0, 0, 0, 2'b00, 3'd5, 16'h000F, 16'h0F00, 16'h0000);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || c_out !== 16'hF0F0 || status !== 3'b010) begin errors++; $display("FAIL b2b_noload: got v=%b C=%h st=%b want v=1 C=F0F0 st=010", out_valid, c_out, status); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_mul();
      drive_op(0, 0, 1, 1, 2'b00, 3'd4, 16'd300, 16'd300, 16'h0000);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) in_valid = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || c_out !== 16'h0000 || status !== 3'b000) begin errors++; $display("FAIL midmul_reset_clear: got v=%b C=%h st=%b want v=0 C=0000 st=000", out_valid, c_out, status); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midmul_reset_ready: got %b want 0", in_ready); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midmul_release_ready: got %b want 1", in_ready); end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0 || c_out !== 16'h0000) begin errors++; $display("FAIL midmul_no_complete cyc %0d: got v=%b C=%h want v=0 C=0000", i, out_valid, c_out); end
      end
      drive_op(0, 0, 1, 1, 2'b00, 3'd0, 16'd2, 16'd2, 16'h0000);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || c_out !== 16'h0004 || status !== 3'b000) begin errors++; $display("FAIL post_reset_add: got v=%b C=%h st=%b want v=1 C=0004 st=000", out_valid, c_out, status); end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_sub_loads();
      test_shift_bsel();
      test_mul();
      test_back_to_back();
      test_reset_mid_mul();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
